// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer around a combinational 32-bit ALU with an 8x32 register file.
// Optional sticky illegal-opcode trap enabled by defining ALU_SEQ_ILLEGAL_TRAP_EN.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [15:0]       InInstr,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutResult,
  output logic [2:0]        OutRd,
  output logic [DATA_W-1:0] AluOperand1,
  output logic [DATA_W-1:0] AluOperand2,
  output logic [3:0]        AluOpcode,
  input  logic [DATA_W-1:0] AluResult,
  input  logic              HostWrEn,
  input  logic [2:0]        HostWrAddr,
  input  logic [DATA_W-1:0] HostWrData,
  output logic [CNT_W-1:0]  InstrCount,
  output logic              Err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [3:0] opc);
    logic ok;
    case (opc)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [8];
  logic [DATA_W-1:0]   regs_d [8];
  logic [2:0]          rd_q, rd_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [3:0]          opc_q, opc_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [2:0]          out_rd_q, out_rd_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic                exec_legal_s;
  logic                wb_en_s;
  logic                unused_instr_hi_s;

  assign unused_instr_hi_s = ^InInstr[15:13];

  assign exec_legal_s = is_legal(opc_q);
  assign wb_en_s      = (state_q == EXEC) && exec_legal_s;

  // Next-state and datapath: host writes and writeback merge into the register file, writeback wins.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    opc_d       = opc_q;
    result_d    = result_q;
    out_rd_d    = out_rd_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;
    err_d       = err_q;

    for (int i = 0; i < 8; i++) begin
      if (wb_en_s && (rd_q == 3'(i))) begin
        regs_d[i] = AluResult;
      end else if (HostWrEn && (HostWrAddr == 3'(i))) begin
        regs_d[i] = HostWrData;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (InValid) begin
          // Operands see a host write landing on the same edge as acceptance.
          op1_d      = regs_d[InInstr[9:7]];
          op2_d      = regs_d[InInstr[12:10]];
          opc_d      = InInstr[3:0];
          rd_d       = InInstr[6:4];
          in_ready_d = 1'b0;
          state_d    = EXEC;
        end else begin
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      EXEC: begin
        result_d    = exec_legal_s ? AluResult : {DATA_W{1'b0}};
        out_rd_d    = rd_q;
        count_d     = count_q + CNT_W'(1);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        err_d       = err_q | ~exec_legal_s;
`else
        err_d       = 1'b0;
`endif
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = RESP;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      rd_q        <= 3'd0;
      op1_q       <= {DATA_W{1'b0}};
      op2_q       <= {DATA_W{1'b0}};
      opc_q       <= 4'd0;
      result_q    <= {DATA_W{1'b0}};
      out_rd_q    <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_q        <= rd_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      opc_q       <= opc_d;
      result_q    <= result_d;
      out_rd_q    <= out_rd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign InReady     = in_ready_q;
  assign OutValid    = out_valid_q;
  assign OutResult   = result_q;
  assign OutRd       = out_rd_q;
  assign AluOperand1 = op1_q;
  assign AluOperand2 = op2_q;
  assign AluOpcode   = opc_q;
  assign InstrCount  = count_q;
  assign Err         = err_q;

endmodule
